// File: rtl/vga_pattern_gen_pkg.sv
// Shared types and constants for the VGA test-pattern generator:
// FSM encoding, pattern codes, bar colours and the per-pixel colour rule.
package vga_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Only the low byte of each coordinate feeds the colour rule.
  function automatic logic [23:0] pattern_px(input pattern_e    sel,
                                             input logic [23:0] solid,
                                             input logic [23:0] bar,
                                             input logic [7:0]  xl,
                                             input logic [7:0]  yl,
                                             input logic [7:0]  frame_lsb);
    logic [7:0] ramp_r;
    ramp_r = xl + frame_lsb;
    case (sel)
      PAT_BARS:  return bar;
      PAT_CHECK: return (xl[5] ^ yl[5]) ? COL_BLACK : COL_WHITE;
      PAT_RAMP:  return {ramp_r, yl, 8'h00};
      default:   return solid;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel stream between the pattern generator and the VGA core:
// RGB data with valid/ready handshake plus start-of-frame and end-of-line flags.
interface vga_pix_if;
  logic [7:0] pxl_red;
  logic [7:0] pxl_green;
  logic [7:0] pxl_blue;
  logic       pxl_valid;
  logic       pxl_ready;
  logic       pxl_sof;
  logic       pxl_eol;

  modport master (
    output pxl_red, pxl_green, pxl_blue, pxl_valid, pxl_sof, pxl_eol,
    input  pxl_ready
  );

  modport slave (
    input  pxl_red, pxl_green, pxl_blue, pxl_valid, pxl_sof, pxl_eol,
    output pxl_ready
  );
endinterface

// File: rtl/vga_pattern_gen_bar_lut.sv
// Colour-bar lookup: bar index 0..7 to 24-bit RGB, purely combinational.
module vga_bar_lut
  import vga_pkg::*;
(
  input  logic [2:0]  bar_idx,
  output logic [23:0] bar_rgb
);

  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = COL_WHITE;
      3'd1:    bar_rgb = COL_YELLOW;
      3'd2:    bar_rgb = COL_CYAN;
      3'd3:    bar_rgb = COL_GREEN;
      3'd4:    bar_rgb = COL_MAGENTA;
      3'd5:    bar_rgb = COL_RED;
      3'd6:    bar_rgb = COL_BLUE;
      default: bar_rgb = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: streams one frame of bars/checker/ramp/solid pixels
// per LOAD, with geometry and pattern frozen in shadow registers for the frame.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | no pixel offered; waits for enable
//   S_LOAD | one cycle: latch config, present pixel (0,0) on the next edge
//   S_RUN  | offer pixels; advance on each transfer until frame end
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic        pxl_clk,
  input  logic        pxl_rst,
  input  logic        enable,
  input  logic [31:0] horiz_res,
  input  logic [31:0] vert_res,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [15:0] frame_cnt,
  vga_pix_if.master   pix
);

  state_e      state;
  logic [11:0] x, y;
  logic [11:0] h_last, v_last;
  pattern_e    sel_sh;
  logic [23:0] rgb_sh;
  logic [8:0]  bar_w_m1;
  logic [2:0]  bar_idx;
  logic [8:0]  bar_rem;

  logic [11:0] nx_x, nx_y, nx_h_last;
  logic [2:0]  nx_idx;
  logic [8:0]  nx_rem;
  pattern_e    nx_sel;
  logic [23:0] nx_solid;
  logic [23:0] bar_rgb;
  logic [23:0] nx_pix;
  logic        xfer, frame_done, present;

  // Resolutions above 4095 are illegal, so the upper port bits carry nothing.
  logic unused_res_bits;
  assign unused_res_bits = ^{horiz_res[31:12], vert_res[31:12]};

  assign xfer       = pix.pxl_valid & pix.pxl_ready;
  assign frame_done = (x == h_last) && (y == v_last);
  assign present    = (state == S_LOAD) || ((state == S_RUN) && xfer && !frame_done);

  // Coordinates and bar counter of the pixel to present next; during LOAD they
  // come from the live ports because the shadows are being written that edge.
  always_comb begin
    nx_x      = '0;
    nx_y      = '0;
    nx_idx    = '0;
    nx_rem    = bar_w_m1;
    nx_sel    = sel_sh;
    nx_solid  = rgb_sh;
    nx_h_last = h_last;
    if (state != S_RUN) begin
      nx_sel    = pattern_e'(pattern_sel);
      nx_solid  = solid_rgb;
      nx_h_last = horiz_res[11:0] - 12'd1;
      nx_rem    = horiz_res[11:3] - 9'd1;
    end else if (x == h_last) begin
      nx_y = y + 12'd1;
    end else begin
      nx_x = x + 12'd1;
      nx_y = y;
      // Bar 7 absorbs the remainder pixels, so its down-counter just parks.
      if (bar_idx == 3'd7) begin
        nx_idx = bar_idx;
        nx_rem = bar_rem;
      end else if (bar_rem == '0) begin
        nx_idx = bar_idx + 3'd1;
        nx_rem = bar_w_m1;
      end else begin
        nx_idx = bar_idx;
        nx_rem = bar_rem - 9'd1;
      end
    end
  end

  vga_bar_lut u_bar_lut (
    .bar_idx (nx_idx),
    .bar_rgb (bar_rgb)
  );

  assign nx_pix = pattern_px(nx_sel, nx_solid, bar_rgb, nx_x[7:0], nx_y[7:0], frame_cnt[7:0]);

  always_ff @(posedge pxl_clk) begin
    if (pxl_rst) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      h_last        <= '0;
      v_last        <= '0;
      sel_sh        <= PAT_BARS;
      rgb_sh        <= '0;
      bar_w_m1      <= '0;
      bar_idx       <= '0;
      bar_rem       <= '0;
      frame_cnt     <= '0;
      pix.pxl_valid <= 1'b0;
      pix.pxl_sof   <= 1'b0;
      pix.pxl_eol   <= 1'b0;
      pix.pxl_red   <= '0;
      pix.pxl_green <= '0;
      pix.pxl_blue  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          h_last   <= nx_h_last;
          v_last   <= vert_res[11:0] - 12'd1;
          sel_sh   <= nx_sel;
          rgb_sh   <= nx_solid;
          bar_w_m1 <= nx_rem;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (xfer && frame_done) begin
            frame_cnt     <= frame_cnt + 16'd1;
            pix.pxl_valid <= 1'b0;
            pix.pxl_sof   <= 1'b0;
            pix.pxl_eol   <= 1'b0;
            state         <= enable ? S_LOAD : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (present) begin
        x             <= nx_x;
        y             <= nx_y;
        bar_idx       <= nx_idx;
        bar_rem       <= nx_rem;
        pix.pxl_valid <= 1'b1;
        pix.pxl_sof   <= (nx_x == '0) && (nx_y == '0);
        pix.pxl_eol   <= (nx_x == nx_h_last);
        pix.pxl_red   <= nx_pix[23:16];
        pix.pxl_green <= nx_pix[15:8];
        pix.pxl_blue  <= nx_pix[7:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: captures accepted pixels and compares them with an
// arithmetic model of the pattern rules plus a table of fixed spot values.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] horiz_res;
  logic [31:0] vert_res;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vga_pix_if pix ();

  vga_pattern_gen dut (
    .pxl_clk     (clk),
    .pxl_rst     (rst),
    .enable      (enable),
    .horiz_res   (horiz_res),
    .vert_res    (vert_res),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .frame_cnt   (frame_cnt),
    .pix         (pix)
  );

  typedef struct {
    int          test_id;
    int          idx;
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
  } vec_t;

  vec_t        vecs[$];
  logic [25:0] cap_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          exp_fc;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] model_px(input int sel, input logic [23:0] rgb,
                                           input int h, input int x, input int y,
                                           input int fc);
    int bw, bi;
    case (sel)
      0: begin
        bw = h / 8;
        bi = x / bw;
        if (bi > 7) bi = 7;
        return bar_tab[bi];
      end
      1: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
      2: return {8'((x + fc) % 256), 8'(y % 256), 8'h00};
      default: return rgb;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;
  endtask

  // Runs the handshake for npix transfers; enable drops / config changes right
  // after the indexed pixel is accepted.
  task automatic capture(input int npix, input bit rnd, input int drop_at,
                         input int chg_at, input logic [1:0] chg_sel,
                         input logic [23:0] chg_rgb);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [26:0] held = '0;
    logic [26:0] cur;
    cap_q.delete();
    enable = 1'b1;
    while (got < npix && cyc < npix * 4 + 200) begin
      @(negedge clk);
      cyc++;
      cur = {pix.pxl_valid, pix.pxl_red, pix.pxl_green, pix.pxl_blue, pix.pxl_sof, pix.pxl_eol};
      if (stalled) chk("stall_hold", 64'(cur), 64'(held));
      pix.pxl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix.pxl_valid && pix.pxl_ready) begin
        cap_q.push_back(cur[25:0]);
        if (got == drop_at) enable = 1'b0;
        if (got == chg_at) begin
          pattern_sel = chg_sel;
          solid_rgb   = chg_rgb;
        end
        got++;
      end
      stalled = pix.pxl_valid && !pix.pxl_ready;
      held    = cur;
    end
    chk("capture_count", 64'(got), 64'(npix));
  endtask

  task automatic check_frame(input string tag, input int start, input int h, input int v,
                             input int sel, input logic [23:0] rgb, input int fc);
    int          idx;
    logic [25:0] act;
    logic [25:0] exp;
    for (int yy = 0; yy < v; yy++) begin
      for (int xx = 0; xx < h; xx++) begin
        idx = start + yy * h + xx;
        act = (idx < cap_q.size()) ? cap_q[idx] : 'x;
        exp = {model_px(sel, rgb, h, xx, yy, fc), (xx == 0 && yy == 0), (xx == h - 1)};
        chk($sformatf("%s_px%0d", tag, idx), 64'(act), 64'(exp));
      end
    end
  endtask

  task automatic apply_vecs(input int id);
    logic [25:0] act;
    foreach (vecs[i]) begin
      if (vecs[i].test_id == id) begin
        act = (vecs[i].idx < cap_q.size()) ? cap_q[vecs[i].idx] : 'x;
        chk($sformatf("vec%0d_px%0d", id, vecs[i].idx), 64'(act),
            64'({vecs[i].rgb, vecs[i].sof, vecs[i].eol}));
      end
    end
  endtask

  task automatic settle_check(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_valid_low"}, 64'(pix.pxl_valid), 64'(0));
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_fc));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h, v, sel, n_valid;
    logic [23:0] rgb;

    vecs.push_back('{0, 0,    24'hFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{0, 79,   24'hFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{0, 80,   24'hFFFF00, 1'b0, 1'b0});
    vecs.push_back('{0, 639,  24'h000000, 1'b0, 1'b1});
    vecs.push_back('{0, 640,  24'hFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{0, 1279, 24'h000000, 1'b0, 1'b1});
    vecs.push_back('{1, 559,  24'h0000FF, 1'b0, 1'b0});
    vecs.push_back('{1, 560,  24'h000000, 1'b0, 1'b0});
    vecs.push_back('{1, 643,  24'h000000, 1'b0, 1'b0});
    vecs.push_back('{1, 644,  24'h000000, 1'b0, 1'b1});
    vecs.push_back('{2, 30,   24'h123456, 1'b0, 1'b0});
    vecs.push_back('{2, 127,  24'h123456, 1'b0, 1'b1});
    vecs.push_back('{2, 128,  24'hFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{2, 160,  24'h000000, 1'b0, 1'b0});

    rst = 1'b1;
    enable = 1'b0;
    horiz_res = 640;
    vert_res = 2;
    pattern_sel = 2'd0;
    solid_rgb = '0;
    pix.pxl_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(pix.pxl_valid), 64'(0));
    chk("rst_sof_eol", 64'({pix.pxl_sof, pix.pxl_eol}), 64'(0));
    chk("rst_rgb", 64'({pix.pxl_red, pix.pxl_green, pix.pxl_blue}), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    rst = 1'b0;
    exp_fc = 0;
    repeat (5) @(negedge clk);
    chk("idle_valid", 64'(pix.pxl_valid), 64'(0));

    // Colour bars, 640x2
    capture(1280, 1'b0, 1279, -1, 2'd0, 24'h0);
    check_frame("bars", 0, 640, 2, 0, 24'h0, exp_fc);
    apply_vecs(0);
    exp_fc++;
    settle_check("bars");

    // Remainder pixels fall into bar 7
    horiz_res = 645;
    vert_res = 1;
    capture(645, 1'b0, 644, -1, 2'd0, 24'h0);
    check_frame("rem", 0, 645, 1, 0, 24'h0, exp_fc);
    apply_vecs(1);
    exp_fc++;
    settle_check("rem");

    // Ramp under random backpressure, starting from frame_cnt 0
    do_reset();
    horiz_res = 300;
    vert_res = 2;
    pattern_sel = 2'd2;
    capture(600, 1'b1, 599, -1, 2'd0, 24'h0);
    check_frame("ramp", 0, 300, 2, 2, 24'h0, exp_fc);
    exp_fc++;
    settle_check("ramp");

    // Mid-frame config change only lands at the next LOAD
    horiz_res = 64;
    vert_res = 2;
    pattern_sel = 2'd3;
    solid_rgb = 24'h123456;
    capture(256, 1'b0, 255, 20, 2'd1, 24'hABCDEF);
    check_frame("cfg_f0", 0, 64, 2, 3, 24'h123456, exp_fc);
    check_frame("cfg_f1", 128, 64, 2, 1, 24'hABCDEF, exp_fc + 1);
    apply_vecs(2);
    exp_fc += 2;
    settle_check("cfg");

    // Randomised geometry/pattern, two back-to-back frames each
    for (int it = 0; it < 4; it++) begin
      h = $urandom_range(8, 80);
      v = $urandom_range(1, 3);
      sel = $urandom_range(0, 3);
      rgb = 24'($urandom);
      horiz_res = h;
      vert_res = v;
      pattern_sel = 2'(sel);
      solid_rgb = rgb;
      capture(2 * h * v, 1'b1, 2 * h * v - 1, -1, 2'd0, 24'h0);
      check_frame($sformatf("rnd%0d_f0", it), 0, h, v, sel, rgb, exp_fc);
      check_frame($sformatf("rnd%0d_f1", it), h * v, h, v, sel, rgb, exp_fc + 1);
      exp_fc += 2;
      settle_check($sformatf("rnd%0d", it));
    end

    // Enable dropped at y=1 of a 4-line frame: frame completes, then idle
    do_reset();
    horiz_res = 16;
    vert_res = 4;
    pattern_sel = 2'd0;
    capture(64, 1'b0, 16, -1, 2'd0, 24'h0);
    check_frame("en_drop", 0, 16, 4, 0, 24'h0, exp_fc);
    exp_fc = 1;
    settle_check("en_drop");
    n_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (pix.pxl_valid) n_valid++;
    end
    chk("en_drop_stays_idle", 64'(n_valid), 64'(0));

    // Reset in the middle of a frame
    capture(10, 1'b0, -1, -1, 2'd0, 24'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(pix.pxl_valid), 64'(0));
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
    rst = 1'b0;
    exp_fc = 0;
    capture(64, 1'b0, 63, -1, 2'd0, 24'h0);
    check_frame("post_rst", 0, 16, 4, 0, 24'h0, exp_fc);
    exp_fc = 1;
    settle_check("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
